fifo_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ producers.

---
 rtl/gpu_fifo_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/fifo_write_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fifo_pkg.sv
// Shared definitions for the GPU FIFO write/read-side schedulers.
package gpu_fifo_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping mod NUM_REQ.
module rr_priority_pick
  import gpu_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] pick,
  output logic                any
);

  localparam int unsigned SUM_W = ID_WIDTH + 1;

  if (ID_WIDTH < clog2(NUM_REQ)) begin : g_bad_id_width
    $error("rr_priority_pick: ID_WIDTH too small for NUM_REQ");
  end

  logic [NUM_REQ-1:0]  rotated;
  logic [ID_WIDTH-1:0] first;
  logic [SUM_W-1:0]    sum;

  // Rotate so that bit 0 is the request at ptr; the lowest set bit then wins.
  always_comb begin
    rotated = NUM_REQ'({req, req} >> ptr);
    first   = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (rotated[k-1]) first = ID_WIDTH'(k - 1);
    end
    sum = {1'b0, ptr} + {1'b0, first};
    if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
    pick = sum[ID_WIDTH-1:0];
    any  = |req;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ bursting producers.
module fifo_write_arbiter
  import gpu_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam int unsigned CNT_W = clog2(MAX_BURST) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_write_arbiter: NUM_REQ must be 2..8");
  end
  if (ID_WIDTH < clog2(NUM_REQ)) begin : g_bad_id_width
    $error("fifo_write_arbiter: ID_WIDTH too small for NUM_REQ");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("fifo_write_arbiter: MAX_BURST must be 1..15");
  end

  arb_state_t          state;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] next_ptr;
  logic [ID_WIDTH-1:0] pick;
  logic [CNT_W-1:0]    beat_cnt;
  logic                any_req;
  logic                owner_valid;
  logic                owner_last;
  logic                can_write;
  logic                beat;
  logic                burst_done;
  logic                release_grant;
  logic                take_grant;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (any_req)
  );

  always_comb begin
    owner_valid     = 1'b0;
    owner_last      = 1'b0;
    fifo_write_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_WIDTH'(i)) begin
        owner_valid     = req_valid[i];
        owner_last      = req_last[i];
        fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gating with reset keeps a dropped burst from leaking a write in the reset cycle.
  assign can_write = (state == ARB_LOCKED) & ~fifo_full & ~reset;
  assign beat      = can_write & owner_valid;
  assign fifo_wen  = beat;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_WIDTH'(i)) req_ready[i] = can_write;
    end
  end

  assign burst_done    = owner_last | (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign release_grant = (state == ARB_LOCKED) & ((beat & burst_done) | ~owner_valid);
  assign take_grant    = (state == ARB_IDLE) & any_req & ~fifo_almost_full;
  assign next_ptr      = (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (take_grant) begin
            state    <= ARB_LOCKED;
            owner    <= pick;
            grant_id <= pick;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (beat) beat_cnt <= beat_cnt + 1'b1;
          if (release_grant) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: directed producer bursts, expected FIFO writes checked by a monitor.
module tb_fifo_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned DW = 4;
  localparam int unsigned MB = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_wen;
  logic [DW-1:0] fifo_write_data;
  logic [IW-1:0] grant_id;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t        sb[$];
  int          wr_cyc[$];
  logic [DW:0] pq[N][$];
  logic [N-1:0] hs;
  logic [DW:0]  w;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .ID_WIDTH   (IW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wen         (fifo_wen),
    .fifo_write_data  (fifo_write_data),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (fifo_wen) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_write", {28'd0, fifo_write_data}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_data", 32'(fifo_write_data), 32'(e.data));
        chk("wr_grant_id", 32'(grant_id), 32'(e.id));
        chk("wr_ready_onehot", 32'(req_ready), 32'd1 << e.id);
        chk("wr_busy", 32'(busy), 32'd1);
      end
    end
  end

  // Producers: hold each queued word valid until it is accepted.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          w = pq[i][0];
          req_valid[i]          = 1'b1;
          req_last[i]           = w[DW];
          req_data[i*DW +: DW]  = w[DW-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add_word(input int r, input logic [DW-1:0] d, input logic l);
    pq[r].push_back({l, d});
  endtask

  task automatic expect_wr(input int r, input logic [DW-1:0] d);
    exp_t e;
    e.id   = IW'(r);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (4) tick();
  endtask

  task automatic wait_writes(input int k);
    int n;
    n = 0;
    while (wr_cyc.size() < k && n < 100) begin
      tick();
      n++;
    end
    if (wr_cyc.size() < k) chk("write_wait_timeout", wr_cyc.size(), k);
  endtask

  task automatic chk_gap(input int i, input int exp);
    if (wr_cyc.size() > i + 1)
      chk($sformatf("write_gap_%0d", i), wr_cyc[i+1] - wr_cyc[i], exp);
    else
      chk($sformatf("write_gap_%0d_missing", i), wr_cyc.size(), i + 2);
  endtask

  initial begin
    int gaps2[11];
    reset            = 1'b1;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    chk("reset_wen", fifo_wen, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_grant_id", grant_id, 0);

    // 1: requesters 0 and 2, single-beat bursts
    wr_cyc.delete();
    add_word(0, 4'h1, 1'b1);
    add_word(2, 4'h2, 1'b1);
    expect_wr(0, 4'h1);
    expect_wr(2, 4'h2);
    drain();
    chk("t1_writes", wr_cyc.size(), 2);
    chk_gap(0, 2);

    // 2: rr_ptr=3 so requester 3 first, then requester 1 streams 10 words as 4,4,2
    wr_cyc.delete();
    add_word(3, 4'h3, 1'b0);
    add_word(3, 4'h4, 1'b1);
    for (int j = 0; j < 10; j++) add_word(1, DW'(5 + j), 1'b0);
    expect_wr(3, 4'h3);
    expect_wr(3, 4'h4);
    for (int j = 0; j < 10; j++) expect_wr(1, DW'(5 + j));
    drain();
    chk("t2_writes", wr_cyc.size(), 12);
    gaps2 = '{1, 2, 1, 1, 1, 2, 1, 1, 1, 2, 1};
    for (int i = 0; i < 11; i++) chk_gap(i, gaps2[i]);

    // 3: all four streaming 5 words each, rr_ptr=2 -> order 2,3,0,1 x4 then 2,3,0,1 x1
    wr_cyc.delete();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < 5; j++) add_word(r, DW'((r * 5 + j) % 16), 1'b0);
    for (int j = 0; j < 4; j++) expect_wr(2, DW'((10 + j) % 16));
    for (int j = 0; j < 4; j++) expect_wr(3, DW'((15 + j) % 16));
    for (int j = 0; j < 4; j++) expect_wr(0, DW'(j));
    for (int j = 0; j < 4; j++) expect_wr(1, DW'(5 + j));
    expect_wr(2, DW'(14));
    expect_wr(3, DW'(19 % 16));
    expect_wr(0, DW'(4));
    expect_wr(1, DW'(9));
    drain();
    chk("t3_writes", wr_cyc.size(), 20);
    for (int i = 0; i < 19; i++) chk_gap(i, (i >= 16) ? 3 : ((i % 4 == 3) ? 2 : 1));

    // 4: fifo_full for 3 cycles in the middle of a 4-beat burst
    wr_cyc.delete();
    for (int j = 0; j < 4; j++) add_word(0, DW'(1 + j), (j == 3));
    for (int j = 0; j < 4; j++) expect_wr(0, DW'(1 + j));
    wait_writes(2);
    fifo_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("full_ready", req_ready, 0);
      chk("full_wen", fifo_wen, 0);
      chk("full_busy", busy, 1);
      chk("full_owner", grant_id, 0);
    end
    tick();
    fifo_full = 1'b0;
    drain();
    chk("t4_writes", wr_cyc.size(), 4);
    chk_gap(0, 1);
    chk_gap(1, 4);
    chk_gap(2, 1);

    // 5: almost_full blocks a new grant for requester 3
    fifo_almost_full = 1'b1;
    tick();
    add_word(3, 4'hA, 1'b1);
    expect_wr(3, 4'hA);
    repeat (4) begin
      tick();
      @(negedge clk);
      chk("af_busy", busy, 0);
      chk("af_wen", fifo_wen, 0);
    end
    tick();
    fifo_almost_full = 1'b0;
    @(negedge clk);
    chk("af_drop_busy", busy, 0);
    chk("af_drop_grant_id", grant_id, 0);
    @(negedge clk);
    chk("af_grant_id", grant_id, 3);
    chk("af_grant_busy", busy, 1);
    drain();

    // 6: reset in the middle of a requester-2 burst (rr_ptr=2 before reset)
    add_word(1, 4'h5, 1'b1);
    expect_wr(1, 4'h5);
    drain();
    wr_cyc.delete();
    for (int j = 0; j < 4; j++) add_word(2, DW'(6 + j), (j == 3));
    expect_wr(2, 4'h6);
    expect_wr(2, 4'h7);
    wait_writes(2);
    reset = 1'b1;
    pq[2].delete();
    @(negedge clk);
    chk("rst_cycle_wen", fifo_wen, 0);
    chk("rst_cycle_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after_busy", busy, 0);
    chk("rst_after_grant_id", grant_id, 0);
    chk("rst_after_wen", fifo_wen, 0);
    drain();
    chk("t6_writes", wr_cyc.size(), 2);
    add_word(0, 4'hB, 1'b1);
    add_word(3, 4'hC, 1'b1);
    expect_wr(0, 4'hB);
    expect_wr(3, 4'hC);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
